rvv_vd_collector: RTL

// Receive end of the vector ALU lane outputs: accepts per-lane results (data, element index, valid)

---
 rtl/rvv_pkg.sv | 31 +++
 rtl/rvv_lane_merge.sv | 64 ++++++
 rtl/rvv_vd_collector.sv | 135 +++++++++++++
 3 files changed

// File: rtl/rvv_pkg.sv
// ---------------------------------------------------------------------------
// rvv_pkg: shared vsew encodings, collector FSM states and SEW helpers
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package rvv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_WB      = 2'd2
  } state_e;

  localparam logic [2:0]  VSEW_E8  = 3'd0;
  localparam logic [2:0]  VSEW_E16 = 3'd1;
  localparam logic [2:0]  VSEW_E32 = 3'd2;
  localparam logic [2:0]  VSEW_E64 = 3'd3;
  localparam logic [16:0] ELEM_MAX = 17'h1FFFF;

  function automatic int unsigned sew_bits(input logic [2:0] vsew);
    return 32'd8 << vsew[1:0];
  endfunction

  function automatic logic vsew_reserved(input logic [2:0] vsew);
    return vsew[2];
  endfunction

endpackage

`default_nettype wire

// File: rtl/rvv_lane_merge.sv
// ---------------------------------------------------------------------------
// rvv_lane_merge: one lane's write into the destination image (combinational)
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rvv_lane_merge
  import rvv_pkg::*;
#(
  parameter int VLEN = 128
) (
  input  logic [VLEN-1:0] img_i,
  input  logic [2:0]      vsew_i,
  input  logic            mask_mode_i,
  input  logic [16:0]     vl_i,
  input  logic            valid_i,
  input  logic [16:0]     idx_i,
  input  logic [63:0]     data_i,
  output logic [VLEN-1:0] img_o,
  output logic            wr_o,
  output logic            oor_o
);

  localparam int IW = $clog2(VLEN);

  logic [31:0]   emax;
  logic          in_range;
  logic [IW-1:0] ib;
  logic [IW-1:0] base;

  always_comb begin
    emax = 32'd0;
    if (mask_mode_i) begin
      emax = 32'(VLEN);
    end else if (!vsew_reserved(vsew_i)) begin
      emax = 32'(VLEN) / sew_bits(vsew_i);
    end
    in_range = (32'(idx_i) < emax) && (idx_i < vl_i);
    wr_o     = valid_i && in_range;
    oor_o    = valid_i && !in_range;

    // Low index bits suffice once in_range holds; base is the element's bit offset.
    ib   = idx_i[IW-1:0];
    base = (ib << 3) << vsew_i[1:0];

    img_o = img_i;
    if (wr_o) begin
      if (mask_mode_i) begin
        img_o[ib] = data_i[0];
      end else begin
        case (vsew_i)
          VSEW_E8:  img_o[base +: 8]  = data_i[7:0];
          VSEW_E16: img_o[base +: 16] = data_i[15:0];
          VSEW_E32: img_o[base +: 32] = data_i[31:0];
          VSEW_E64: img_o[base +: 64] = data_i[63:0];
          default:  ;
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/rvv_vd_collector.sv
// ---------------------------------------------------------------------------
// rvv_vd_collector: merges ALU lane results into a vd image and offers it for writeback
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rvv_vd_collector
  import rvv_pkg::*;
#(
  parameter int VLEN     = 128,
  parameter int NB_LANES = 1
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic                          start_i,
  input  logic [2:0]                    vsew_i,
  input  logic [16:0]                   vl_i,
  input  logic                          mask_mode_i,
  input  logic [VLEN-1:0]               vd_old_i,
  input  logic [(1<<NB_LANES)-1:0]      lane_valid_i,
  input  logic [64*(1<<NB_LANES)-1:0]   lane_data_i,
  input  logic [17*(1<<NB_LANES)-1:0]   lane_idx_i,
  input  logic                          alu_done_i,
  output logic                          wb_valid_o,
  input  logic                          wb_ready_i,
  output logic [VLEN-1:0]               wb_data_o,
  output logic [16:0]                   elem_count_o,
  output logic                          busy_o,
  output logic                          err_o
);

  localparam int NL = 1 << NB_LANES;

  state_e          state_q;
  logic [VLEN-1:0] img_q;
  logic [VLEN-1:0] img_d;
  logic [2:0]      vsew_q;
  logic [16:0]     vl_q;
  logic            mask_q;
  logic [16:0]     cnt_q;
  logic [16:0]     cnt_d;
  logic            err_q;
  logic            err_d;
  logic            wb_valid_q;

  logic [VLEN-1:0] chain [NL+1];
  logic [NL-1:0]   wr;
  logic [NL-1:0]   oor;
  logic [17:0]     sum;

  // Lanes are chained in order so a later lane overwrites an earlier one on a shared index.
  assign chain[0] = img_q;

  generate
    for (genvar g = 0; g < NL; g++) begin : g_lane
      rvv_lane_merge #(.VLEN(VLEN)) u_merge (
        .img_i       (chain[g]),
        .vsew_i      (vsew_q),
        .mask_mode_i (mask_q),
        .vl_i        (vl_q),
        .valid_i     (lane_valid_i[g]),
        .idx_i       (lane_idx_i[17*g +: 17]),
        .data_i      (lane_data_i[64*g +: 64]),
        .img_o       (chain[g+1]),
        .wr_o        (wr[g]),
        .oor_o       (oor[g])
      );
    end
  endgenerate

  always_comb begin
    img_d = chain[NL];
    err_d = err_q | (|oor);
    sum   = {1'b0, cnt_q};
    for (int i = 0; i < NL; i++) begin
      sum = sum + {17'b0, wr[i]};
    end
    cnt_d = (sum > {1'b0, ELEM_MAX}) ? ELEM_MAX : sum[16:0];
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= ST_IDLE;
      img_q      <= '0;
      vsew_q     <= '0;
      vl_q       <= '0;
      mask_q     <= 1'b0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      wb_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            img_q   <= vd_old_i;
            vsew_q  <= vsew_i;
            vl_q    <= vl_i;
            mask_q  <= mask_mode_i;
            cnt_q   <= '0;
            err_q   <= vsew_reserved(vsew_i) && !mask_mode_i;
            state_q <= ST_COLLECT;
          end
        end
        ST_COLLECT: begin
          img_q <= img_d;
          cnt_q <= cnt_d;
          err_q <= err_d;
          if (alu_done_i) begin
            state_q    <= ST_WB;
            wb_valid_q <= 1'b1;
          end
        end
        ST_WB: begin
          if (wb_ready_i) begin
            state_q    <= ST_IDLE;
            wb_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q    <= ST_IDLE;
          wb_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign wb_valid_o   = wb_valid_q;
  assign wb_data_o    = img_q;
  assign elem_count_o = cnt_q;
  assign busy_o       = (state_q != ST_IDLE);
  assign err_o        = err_q;

endmodule

`default_nettype wire
